multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM sequencing the CPU datapath (PC, IR, register file, ALU) over
//  FETCH/DECODE/EXEC/WB. Replaces the single-cycle opcode decode for the same instruction
//  set: R-type, BEQ, BNE, ADDI, SLTI, LUI, ORI. Handshakes with instruction memory.
//  Faults on memory timeout or an illegal opcode.
// PARAMETERS
//  OP_W     6   opcode width
//  TIMEOUT  16  max cycles FETCH waits for imem_ack_i before FAULT (>=1)
// PORTS
//  clk_i        in   1    clock, rising edge
//  rst_i        in   1    asynchronous, active-high reset
//  start_i      in   1    leave IDLE and begin fetching
//  halt_i       in   1    return to IDLE at next instruction boundary
//  instr_op_i   in   6    opcode field from memory data; latched when ir_write_o=1
//  imem_req_o   out  1    instruction fetch request
//  imem_ack_i   in   1    fetch data valid this cycle
//  zero_i       in   1    ALU zero flag
//  ir_write_o   out  1    load IR
//  pc_write_o   out  1    load PC
//  pc_src_o     out  1    0: PC+4, 1: branch target
//  reg_write_o  out  1    register file write enable
//  reg_dst_o    out  1    1: rd, 0: rt
//  alu_src_o    out  1    1: immediate operand
//  alu_op_o     out  3    R 010, BEQ/BNE 001, ADDI 100, SLTI 101, LUI 110, ORI 111, else 000
//  busy_o       out  1    state != IDLE and state != FAULT
//  fault_o      out  2    00 none, 01 timeout, 10 illegal opcode; sticky until reset
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, EXEC, WB, FAULT. Moore outputs from state + latched opcode.
//  - Reset (async, any state): state=IDLE, opcode reg=0, timeout cnt=0, fault_o=00,
//    all outputs 0.
//  - IDLE: start_i=1 -> FETCH; otherwise stay. start_i is ignored in all other states.
//  - FETCH: imem_req_o=1. imem_ack_i=1 -> ir_write_o=1, pc_write_o=1, pc_src_o=0,
//    latch opcode, -> DECODE.
//  - FETCH timeout: counter increments per waiting cycle. If count reaches TIMEOUT-1 with
//    no ack -> FAULT, fault_o=01. An ack in the same cycle as the limit wins: no fault.
//    Counter clears on leaving FETCH.
//  - DECODE: legal opcode -> EXEC; otherwise -> FAULT with fault_o=10.
//  - EXEC: alu_op_o and alu_src_o (ADDI/SLTI/LUI/ORI) are driven from the opcode.
//      - Branch: taken = BEQ & zero_i | BNE & ~zero_i.
//      - Taken branch: pc_write_o=1, pc_src_o=1.
//      - Branch exits to FETCH, or to IDLE if halt_i=1.
//      - Non-branch -> WB.
//  - WB: reg_write_o=1, reg_dst_o=(opcode==R). alu_op_o and alu_src_o hold their EXEC values.
//      -> FETCH, or IDLE if halt_i=1.
//  - halt_i is sampled only at the EXEC-branch and WB exits. It never aborts a fetch.
//  - FAULT: absorbing state. All enables 0, busy_o=0. Exit only via rst_i.
//  - Latency with ack in the first FETCH cycle: ALU instr 4 cycles, branch 3 cycles.
//  - Only one of pc_write_o or reg_write_o is ever high in a given cycle.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined:
//    - Adds outputs cycle_cnt_o[31:0] and instr_cnt_o[31:0].
//    - cycle_cnt_o increments on every cycle with busy_o=1.
//    - instr_cnt_o increments on each WB or EXEC-branch exit.
//    - Both wrap modulo 2^32 and clear on rst_i.
//  MC_CTRL_PERF_EN undefined: these ports and counters do not exist.
// TESTING
//  1. ADDI (op 001000), ack on first FETCH cycle -> states F,D,E,W. alu_op=100, alu_src=1,
//     reg_write=1 in W only, reg_dst=0.
//  2. BEQ, zero_i=1 -> pc_write=1 and pc_src=1 in EXEC, then FETCH.
//     BNE, zero_i=1 -> no pc_write in EXEC.
//  3. Ack withheld: no ack for TIMEOUT cycles -> FAULT, fault_o=01.
//     Ack on cycle TIMEOUT -> DECODE, fault_o=00.
//  4. Opcode 100011 -> FAULT, fault_o=10, busy_o=0. start_i is ignored until rst_i.
//  5. rst_i asserted mid-EXEC (async, between clock edges) -> outputs 0 immediately, state IDLE.
//  6. halt_i=1 during WB of R-type (alu_op=010, reg_dst=1) -> IDLE.
//     With MC_CTRL_PERF_EN: instr_cnt_o=1, cycle_cnt_o=4.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/WB with an imem handshake and sticky faults.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic [OP_W-1:0] instr_op_i,
  output logic            imem_req_o,
  input  logic            imem_ack_i,
  input  logic            zero_i,
  output logic            ir_write_o,
  output logic            pc_write_o,
  output logic            pc_src_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            alu_src_o,
  output logic [2:0]      alu_op_o,
  output logic            busy_o,
  output logic [1:0]      fault_o
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     instr_cnt_o
`endif
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_TIMEOUT = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  opcode_q, opcode_d;
  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic [1:0]       fault_q, fault_d;

  logic       isR, isBeq, isBne, isBranch, isImm, isLegal, brTaken;
  logic [2:0] aluOpDec;

  // Instruction class decode, always from the latched opcode so EXEC and WB agree
  assign isR      = (opcode_q == OP_R);
  assign isBeq    = (opcode_q == OP_BEQ);
  assign isBne    = (opcode_q == OP_BNE);
  assign isBranch = isBeq | isBne;
  assign isImm    = (opcode_q == OP_ADDI) | (opcode_q == OP_SLTI) |
                    (opcode_q == OP_LUI)  | (opcode_q == OP_ORI);
  assign isLegal  = isR | isBranch | isImm;
  assign brTaken  = (isBeq & zero_i) | (isBne & ~zero_i);

  always_comb begin
    aluOpDec = 3'b000;
    if (isR)                         aluOpDec = 3'b010;
    else if (isBranch)               aluOpDec = 3'b001;
    else if (opcode_q == OP_ADDI)    aluOpDec = 3'b100;
    else if (opcode_q == OP_SLTI)    aluOpDec = 3'b101;
    else if (opcode_q == OP_LUI)     aluOpDec = 3'b110;
    else if (opcode_q == OP_ORI)     aluOpDec = 3'b111;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      timeoutCnt_q <= '0;
      fault_q      <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      timeoutCnt_q <= timeoutCnt_d;
      fault_q      <= fault_d;
    end
  end

  // An ack arriving on the last allowed FETCH cycle takes priority over the timeout
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    timeoutCnt_d = timeoutCnt_q;
    fault_d      = fault_q;
    imem_req_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 3'b000;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_write_o   = 1'b1;
          pc_write_o   = 1'b1;
          opcode_d     = instr_op_i;
          timeoutCnt_d = '0;
          state_d      = S_DECODE;
        end else if (timeoutCnt_q == CNT_MAX) begin
          timeoutCnt_d = '0;
          fault_d      = FLT_TIMEOUT;
          state_d      = S_FAULT;
        end else begin
          timeoutCnt_d = timeoutCnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (isLegal) state_d = S_EXEC;
        else begin
          fault_d = FLT_ILLEGAL;
          state_d = S_FAULT;
        end
      end
      S_EXEC: begin
        alu_op_o  = aluOpDec;
        alu_src_o = isImm;
        if (isBranch) begin
          pc_write_o = brTaken;
          pc_src_o   = brTaken;
          state_d    = halt_i ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        alu_op_o    = aluOpDec;
        alu_src_o   = isImm;
        reg_write_o = 1'b1;
        reg_dst_o   = isR;
        state_d     = halt_i ? S_IDLE : S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault_o = fault_q;

`ifdef MC_CTRL_PERF_EN
  logic        instrDone;
  logic [31:0] cycleCnt_q, instrCnt_q;

  // An instruction retires at a WB exit or at the EXEC exit of a branch
  assign instrDone = (state_q == S_WB) || ((state_q == S_EXEC) && isBranch);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycleCnt_q <= '0;
      instrCnt_q <= '0;
    end else begin
      if (busy_o)    cycleCnt_q <= cycleCnt_q + 32'd1;
      if (instrDone) instrCnt_q <= instrCnt_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycleCnt_q;
  assign instr_cnt_o = instrCnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected output vector for each
// cycle, a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, halt = 1'b0, ack = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'b0;
  logic       imemReq, irWrite, pcWrite, pcSrc, regWrite, regDst, aluSrc, busy;
  logic [2:0] aluOp;
  logic [1:0] fault;

  typedef struct {
    logic [12:0] v;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  logic [12:0] actVec;
  assign actVec = {imemReq, irWrite, pcWrite, pcSrc, regWrite, regDst, aluSrc,
                   aluOp, busy, fault};

  multicycle_ctrl #(.OP_W(6), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halt_i(halt),
    .instr_op_i(op), .imem_req_o(imemReq), .imem_ack_i(ack), .zero_i(zero),
    .ir_write_o(irWrite), .pc_write_o(pcWrite), .pc_src_o(pcSrc),
    .reg_write_o(regWrite), .reg_dst_o(regDst), .alu_src_o(aluSrc),
    .alu_op_o(aluOp), .busy_o(busy), .fault_o(fault)
  );

  always #5 clk = ~clk;

  // Vector order: req, irw, pcw, pcs, rw, rd, asrc, aluop[2:0], busy, fault[1:0]
  function automatic logic [12:0] ev(input logic req, irw, pcw, pcs, rw, rd, as,
                                     input logic [2:0] ao, input logic bz,
                                     input logic [1:0] flt);
    return {req, irw, pcw, pcs, rw, rd, as, ao, bz, flt};
  endfunction

  function automatic void pushExp(input logic [12:0] v, input string nm);
    exp_t e;
    e.v = v;
    e.name = nm;
    expQ.push_back(e);
  endfunction

  task automatic applyStimulus(input logic s, h, a, z, input logic [5:0] o,
                               input logic [12:0] v, input string nm);
    @(posedge clk);
    #1;
    start = s; halt = h; ack = a; zero = z; op = o;
    pushExp(v, nm);
  endtask

  // Asserts reset between clock edges and expects all-zero outputs in that same cycle
  task automatic pulseReset(input string nm);
    @(posedge clk);
    #1;
    start = 1'b0; halt = 1'b0; ack = 1'b0; zero = 1'b0;
    #2 rst = 1'b1;
    pushExp(13'b0, nm);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (actVec !== e.v) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, actVec, e.v);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    logic [12:0] z0, fReq, fAck, dec;
    z0   = ev(0,0,0,0,0,0,0,3'b000,0,2'b00);
    fReq = ev(1,0,0,0,0,0,0,3'b000,1,2'b00);
    fAck = ev(1,1,1,0,0,0,0,3'b000,1,2'b00);
    dec  = ev(0,0,0,0,0,0,0,3'b000,1,2'b00);

    applyStimulus(0,0,0,0,6'b000000, z0, "reset_state");
    #1 rst = 1'b0;

    // ADDI with immediate ack, halting in WB
    applyStimulus(1,0,0,0,6'b000000, z0,   "addi_idle");
    applyStimulus(0,0,1,0,6'b001000, fAck, "addi_fetch");
    applyStimulus(0,0,0,0,6'b000000, dec,  "addi_decode");
    applyStimulus(0,0,0,0,6'b000000, ev(0,0,0,0,0,0,1,3'b100,1,2'b00), "addi_exec");
    applyStimulus(0,1,0,0,6'b000000, ev(0,0,0,0,1,0,1,3'b100,1,2'b00), "addi_wb");
    applyStimulus(0,0,0,0,6'b000000, z0,   "addi_idle_after");

    // BEQ taken continues to FETCH, BNE not taken halts
    applyStimulus(1,0,0,0,6'b000000, z0,   "beq_idle");
    applyStimulus(0,0,1,0,6'b000100, fAck, "beq_fetch");
    applyStimulus(0,0,0,0,6'b000000, dec,  "beq_decode");
    applyStimulus(0,0,0,1,6'b000000, ev(0,0,1,1,0,0,0,3'b001,1,2'b00), "beq_exec_taken");
    applyStimulus(0,0,1,0,6'b000101, fAck, "bne_fetch");
    applyStimulus(0,0,0,0,6'b000000, dec,  "bne_decode");
    applyStimulus(0,1,0,1,6'b000000, ev(0,0,0,0,0,0,0,3'b001,1,2'b00), "bne_exec_not_taken");
    applyStimulus(0,0,0,0,6'b000000, z0,   "bne_idle_after");

    // SLTI acked on the last allowed FETCH cycle
    applyStimulus(1,0,0,0,6'b000000, z0,   "slti_idle");
    for (int i = 0; i < 3; i++)
      applyStimulus(0,0,0,0,6'b000000, fReq, "slti_fetch_wait");
    applyStimulus(0,0,1,0,6'b001010, fAck, "slti_fetch_late_ack");
    applyStimulus(0,0,0,0,6'b000000, dec,  "slti_decode");
    applyStimulus(0,0,0,0,6'b000000, ev(0,0,0,0,0,0,1,3'b101,1,2'b00), "slti_exec");
    applyStimulus(0,1,0,0,6'b000000, ev(0,0,0,0,1,0,1,3'b101,1,2'b00), "slti_wb");
    applyStimulus(0,0,0,0,6'b000000, z0,   "slti_idle_after");

    // R-type with halt in WB
    applyStimulus(1,0,0,0,6'b000000, z0,   "r_idle");
    applyStimulus(0,0,1,0,6'b000000, fAck, "r_fetch");
    applyStimulus(0,0,0,0,6'b000000, dec,  "r_decode");
    applyStimulus(0,1,0,0,6'b000000, ev(0,0,0,0,0,0,0,3'b010,1,2'b00), "r_exec_halt_ignored");
    applyStimulus(0,1,0,0,6'b000000, ev(0,0,0,0,1,1,0,3'b010,1,2'b00), "r_wb");
    applyStimulus(0,0,0,0,6'b000000, z0,   "r_idle_after");

    // LUI interrupted by reset mid-EXEC
    applyStimulus(1,0,0,0,6'b000000, z0,   "lui_idle");
    applyStimulus(0,0,1,0,6'b001111, fAck, "lui_fetch");
    applyStimulus(0,0,0,0,6'b000000, dec,  "lui_decode");
    pulseReset("lui_rst_mid_exec");
    applyStimulus(0,0,0,0,6'b000000, z0,   "lui_idle_after_rst");
    applyStimulus(1,0,0,0,6'b000000, z0,   "restart_idle");
    applyStimulus(0,0,0,0,6'b000000, fReq, "restart_fetch");

    // Illegal opcode from a fresh start
    pulseReset("rst_before_illegal");
    applyStimulus(1,0,0,0,6'b000000, z0,   "ill_idle");
    applyStimulus(0,0,1,0,6'b100011, fAck, "ill_fetch");
    applyStimulus(0,0,0,0,6'b000000, dec,  "ill_decode");
    applyStimulus(1,0,1,0,6'b000000, ev(0,0,0,0,0,0,0,3'b000,0,2'b10), "ill_fault");
    applyStimulus(1,0,1,0,6'b001000, ev(0,0,0,0,0,0,0,3'b000,0,2'b10), "ill_fault_sticky");
    pulseReset("rst_clears_fault");

    // Fetch timeout
    applyStimulus(1,0,0,0,6'b000000, z0,   "tmo_idle");
    for (int i = 0; i < 4; i++)
      applyStimulus(0,0,0,0,6'b000000, fReq, "tmo_fetch_wait");
    applyStimulus(1,0,1,0,6'b000000, ev(0,0,0,0,0,0,0,3'b000,0,2'b01), "tmo_fault");
    applyStimulus(1,0,0,0,6'b000000, ev(0,0,0,0,0,0,0,3'b000,0,2'b01), "tmo_fault_sticky");

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
